mem_port_arbiter: RTL and testbench

//  Shares one variable-latency unified memory port between instruction fetch (IF) and load/store (DM).

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_rr_arb2.sv | 22 ++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Grant IDs double as the bit index of each requester in the arbiter request vector.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'b00,
      ARB_BUSY_IF = 2'b01,
      ARB_BUSY_DM = 2'b10
   } arb_state_t;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: bit 0 is IF, bit 1 is DM.
// On a tie the requester that did not win last time gets the grant.
module rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // Pick at most one requester, alternating on ties.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last == GNT_DM) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store,
// stalling the control FSM until the granted access is acknowledged.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic [DATA_W-1:0]     if_rdata,
   output logic                  if_done,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [DATA_W/8-1:0]   dm_be,
   input  logic [ADDR_W-1:0]     dm_addr,
   input  logic [DATA_W-1:0]     dm_wdata,
   output logic [DATA_W-1:0]     dm_rdata,
   output logic                  dm_done,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_ack,
   output logic                  stall,
   output logic                  err_ack
);

   localparam int BE_W = DATA_W / 8;

   arb_state_t  state_r;
   logic        last_grant_r;
   logic [1:0]  elig_s;
   logic [1:0]  gnt_s;

   // Masking with done keeps a held request from being re-granted in its own done cycle.
   assign elig_s = {dm_req & ~dm_done, if_req & ~if_done};
   assign stall  = elig_s[1] | elig_s[0];

   rr_arb2 u_rr_arb2 (
      .req  (elig_s),
      .last (last_grant_r),
      .gnt  (gnt_s)
   );

   // Arbiter FSM with registered memory-side and requester-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ARB_IDLE;
         last_grant_r <= GNT_DM;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_be       <= {BE_W{1'b0}};
         mem_addr     <= {ADDR_W{1'b0}};
         mem_wdata    <= {DATA_W{1'b0}};
         if_done      <= 1'b0;
         dm_done      <= 1'b0;
         if_rdata     <= {DATA_W{1'b0}};
         dm_rdata     <= {DATA_W{1'b0}};
         err_ack      <= 1'b0;
      end else begin
         if_done <= 1'b0;
         dm_done <= 1'b0;
         if (mem_ack && !mem_req) begin
            err_ack <= 1'b1;
         end
         case (state_r)
            ARB_IDLE: begin
               if (gnt_s[GNT_IF]) begin
                  mem_req      <= 1'b1;
                  mem_we       <= 1'b0;
                  mem_be       <= {BE_W{1'b1}};
                  mem_addr     <= if_addr;
                  mem_wdata    <= {DATA_W{1'b0}};
                  last_grant_r <= GNT_IF;
                  state_r      <= ARB_BUSY_IF;
               end else if (gnt_s[GNT_DM]) begin
                  mem_req      <= 1'b1;
                  mem_we       <= dm_we;
                  mem_be       <= dm_we ? dm_be : {BE_W{1'b1}};
                  mem_addr     <= dm_addr;
                  mem_wdata    <= dm_wdata;
                  last_grant_r <= GNT_DM;
                  state_r      <= ARB_BUSY_DM;
               end
            end
            ARB_BUSY_IF: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  if_done  <= 1'b1;
                  if_rdata <= mem_rdata;
                  state_r  <= ARB_IDLE;
               end
            end
            ARB_BUSY_DM: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  dm_done <= 1'b1;
                  if (!mem_we) begin
                     dm_rdata <= mem_rdata;
                  end
                  state_r <= ARB_IDLE;
               end
            end
            default: begin
               mem_req <= 1'b0;
               state_r <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked every cycle,
// plus hand-computed expectations for latency, tie-breaking, stray acks and reset.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = 32'h0;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;
   logic              dm_req = 1'b0;
   logic              dm_we = 1'b0;
   logic [BE_W-1:0]   dm_be = 4'h0;
   logic [ADDR_W-1:0] dm_addr = 32'h0;
   logic [DATA_W-1:0] dm_wdata = 32'h0;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_done;
   logic              mem_req;
   logic              mem_we;
   logic [BE_W-1:0]   mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = 32'h0;
   logic              mem_ack = 1'b0;
   logic              stall;
   logic              err_ack;

   int          errors = 0;
   int          checks = 0;
   logic        cmp_en = 1'b0;
   int          rsp_lat = 1;
   logic [31:0] rsp_data = 32'h0;
   int          stray_cnt = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall(stall), .err_ack(err_ack)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: who owns the port, what it asked for, and what each side sees.
   int          m_own;
   logic        m_last, m_req, m_we, m_if_done, m_dm_done, m_err;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_own <= 0; m_last <= 1'b1; m_req <= 1'b0; m_we <= 1'b0; m_be <= 4'h0;
         m_addr <= 32'h0; m_wdata <= 32'h0; m_if_done <= 1'b0; m_dm_done <= 1'b0;
         m_if_rdata <= 32'h0; m_dm_rdata <= 32'h0; m_err <= 1'b0;
      end else begin
         m_if_done <= 1'b0;
         m_dm_done <= 1'b0;
         if (mem_ack && m_own == 0) m_err <= 1'b1;
         if (m_own != 0) begin
            if (mem_ack) begin
               m_own <= 0;
               m_req <= 1'b0;
               if (m_own == 1) begin
                  m_if_done <= 1'b1;
                  m_if_rdata <= mem_rdata;
               end else begin
                  m_dm_done <= 1'b1;
                  if (!m_we) m_dm_rdata <= mem_rdata;
               end
            end
         end else if (if_req && !m_if_done && !(dm_req && !m_dm_done && m_last == 1'b0)) begin
            m_own <= 1; m_req <= 1'b1; m_we <= 1'b0; m_be <= 4'hF;
            m_addr <= if_addr; m_wdata <= 32'h0; m_last <= 1'b0;
         end else if (dm_req && !m_dm_done) begin
            m_own <= 2; m_req <= 1'b1; m_we <= dm_we; m_be <= dm_we ? dm_be : 4'hF;
            m_addr <= dm_addr; m_wdata <= dm_wdata; m_last <= 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin : compare
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("mem_req", 32'(mem_req), 32'(m_req));
            check("if_done", 32'(if_done), 32'(m_if_done));
            check("dm_done", 32'(dm_done), 32'(m_dm_done));
            check("if_rdata", if_rdata, m_if_rdata);
            check("dm_rdata", dm_rdata, m_dm_rdata);
            check("err_ack", 32'(err_ack), 32'(m_err));
            check("stall", 32'(stall), 32'((if_req & ~m_if_done) | (dm_req & ~m_dm_done)));
            if (m_req) begin
               check("mem_we", 32'(mem_we), 32'(m_we));
               check("mem_be", 32'(mem_be), 32'(m_be));
               check("mem_addr", mem_addr, m_addr);
               check("mem_wdata", mem_wdata, m_wdata);
            end
         end
      end
   end

   // Memory responder: ack rsp_lat cycles into a request, or one stray ack on demand.
   initial begin : responder
      int cnt;
      int seen;
      cnt = 0;
      seen = 0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_ack) begin
            mem_ack = 1'b0;
            cnt = 0;
         end else if (stray_cnt != seen) begin
            seen = stray_cnt;
            mem_ack = 1'b1;
            mem_rdata = rsp_data;
         end else if (mem_req) begin
            cnt++;
            if (cnt >= rsp_lat) begin
               mem_ack = 1'b1;
               mem_rdata = rsp_data;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic next_slot();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input bit is_dm, input int maxc, output int done_at,
                            output int req_cyc, output int stall_cyc,
                            output logic [3:0] be_s, output logic we_s);
      done_at = -1; req_cyc = 0; stall_cyc = 0; be_s = 4'h0; we_s = 1'b0;
      for (int k = 0; k < maxc; k++) begin
         @(negedge clk);
         if (is_dm ? dm_done : if_done) begin
            done_at = k;
            break;
         end
         if (mem_req) begin
            if (req_cyc == 0) begin
               be_s = mem_be;
               we_s = mem_we;
            end
            req_cyc++;
         end
         if (stall) stall_cyc++;
      end
   endtask

   task automatic tie_run(output int if_at, output int dm_at,
                          output logic [31:0] a1, output logic [31:0] a3);
      bit seen_if;
      bit seen_dm;
      if_at = -1; dm_at = -1; a1 = 32'h0; a3 = 32'h0;
      for (int k = 0; k < 10; k++) begin
         seen_if = 1'b0;
         seen_dm = 1'b0;
         @(negedge clk);
         if (k == 1) a1 = mem_addr;
         if (k == 3) a3 = mem_addr;
         if (if_done && if_at < 0) begin if_at = k; seen_if = 1'b1; end
         if (dm_done && dm_at < 0) begin dm_at = k; seen_dm = 1'b1; end
         @(posedge clk);
         #2;
         if (seen_if) if_req = 1'b0;
         if (seen_dm) dm_req = 1'b0;
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench did not finish");
   end

   initial begin : stimulus
      int d, rq, st, ia, da, cnt_done, cnt_req;
      logic [3:0] be_s;
      logic we_s;
      logic [31:0] a1, a3;

      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_done", 32'({if_done, dm_done}), 32'h0);
      check("rst_err", 32'(err_ack), 32'h0);
      check("rst_rdata", if_rdata | dm_rdata, 32'h0);

      // Fetch with the ack three cycles after the request appears
      next_slot();
      if_addr = 32'h0000_3000; rsp_lat = 3; rsp_data = 32'h2408_0005; if_req = 1'b1;
      wait_done(1'b0, 20, d, rq, st, be_s, we_s);
      check("t1_done_cycle", 32'(d), 32'd4);
      check("t1_mem_req_cycles", 32'(rq), 32'd3);
      check("t1_stall_cycles", 32'(st), 32'd4);
      check("t1_if_rdata", if_rdata, 32'h2408_0005);
      next_slot();
      if_req = 1'b0;

      // Load returns data and forces full byte enables
      next_slot();
      dm_we = 1'b0; dm_be = 4'b0001; dm_addr = 32'h20; rsp_lat = 2; rsp_data = 32'h1122_3344;
      dm_req = 1'b1;
      wait_done(1'b1, 20, d, rq, st, be_s, we_s);
      check("t2l_done_cycle", 32'(d), 32'd3);
      check("t2l_be", 32'(be_s), 32'hF);
      check("t2l_dm_rdata", dm_rdata, 32'h1122_3344);
      next_slot();
      dm_req = 1'b0;

      // Store with immediate ack leaves dm_rdata alone
      next_slot();
      dm_we = 1'b1; dm_be = 4'b0100; dm_addr = 32'h10; dm_wdata = 32'h00AB_0000;
      rsp_lat = 1; rsp_data = 32'hDEAD_BEEF; dm_req = 1'b1;
      wait_done(1'b1, 20, d, rq, st, be_s, we_s);
      check("t2s_done_cycle", 32'(d), 32'd2);
      check("t2s_we", 32'(we_s), 32'h1);
      check("t2s_be", 32'(be_s), 32'h4);
      check("t2s_dm_rdata", dm_rdata, 32'h1122_3344);
      check("t2s_if_rdata", if_rdata, 32'h2408_0005);
      next_slot();
      dm_req = 1'b0; dm_we = 1'b0;

      // Tie straight after reset: IF first, DM granted in the IF done cycle
      next_slot(); rst_n = 1'b0;
      next_slot(); rst_n = 1'b1;
      next_slot();
      if_addr = 32'h100; dm_addr = 32'h200; rsp_lat = 1; rsp_data = 32'h5555;
      if_req = 1'b1; dm_req = 1'b1;
      tie_run(ia, da, a1, a3);
      check("t3_if_done_cycle", 32'(ia), 32'd2);
      check("t3_dm_done_cycle", 32'(da), 32'd4);
      check("t3_first_addr", a1, 32'h100);
      check("t3_second_addr", a3, 32'h200);

      // A lone fetch makes IF the last winner, so the next tie goes to DM
      if_addr = 32'h104; if_req = 1'b1;
      wait_done(1'b0, 20, d, rq, st, be_s, we_s);
      check("t3b_done_cycle", 32'(d), 32'd2);
      next_slot();
      if_req = 1'b0;
      next_slot();
      if_addr = 32'h108; dm_addr = 32'h208; rsp_data = 32'h1111;
      if_req = 1'b1; dm_req = 1'b1;
      tie_run(ia, da, a1, a3);
      check("t3c_dm_done_cycle", 32'(da), 32'd2);
      check("t3c_if_done_cycle", 32'(ia), 32'd4);
      check("t3c_first_addr", a1, 32'h208);
      check("t3c_second_addr", a3, 32'h108);

      // Ack while idle is flagged and otherwise ignored
      next_slot();
      rsp_data = 32'hBAD0_BAD0;
      stray_cnt++;
      cnt_done = 0;
      repeat (6) begin
         @(negedge clk);
         if (if_done || dm_done) cnt_done++;
      end
      check("t4_no_done", 32'(cnt_done), 32'd0);
      check("t4_err_ack", 32'(err_ack), 32'h1);
      check("t4_if_rdata", if_rdata, 32'h1111);
      check("t4_dm_rdata", dm_rdata, 32'h1111);

      // Reset in the middle of a load abandons it
      next_slot();
      dm_we = 1'b0; dm_addr = 32'h300; rsp_lat = 6; rsp_data = 32'h7777; dm_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t5_busy", 32'(mem_req), 32'h1);
      next_slot();
      rst_n = 1'b0; dm_req = 1'b0;
      #1;
      check("t5_mem_req_async", 32'(mem_req), 32'h0);
      check("t5_err_cleared", 32'(err_ack), 32'h0);
      check("t5_rdata_cleared", if_rdata | dm_rdata, 32'h0);
      check("t5_mem_addr", mem_addr, 32'h0);
      next_slot();
      rst_n = 1'b1;
      cnt_done = 0; cnt_req = 0;
      repeat (8) begin
         @(negedge clk);
         if (dm_done) cnt_done++;
         if (mem_req) cnt_req++;
      end
      check("t5_no_done", 32'(cnt_done), 32'd0);
      check("t5_no_req", 32'(cnt_req), 32'd0);

      // Held fetch request is not re-granted in its own done cycle
      next_slot();
      if_addr = 32'h400; rsp_lat = 1; rsp_data = 32'h4444; if_req = 1'b1;
      wait_done(1'b0, 20, d, rq, st, be_s, we_s);
      check("t6_done_cycle", 32'(d), 32'd2);
      @(negedge clk);
      check("t6_no_regrant", 32'(mem_req), 32'h0);
      @(negedge clk);
      check("t6_regrant", 32'(mem_req), 32'h1);
      check("t6_regrant_addr", mem_addr, 32'h400);
      wait_done(1'b0, 20, d, rq, st, be_s, we_s);
      check("t6_second_done", 32'(d), 32'd0);
      next_slot();
      if_req = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
